// File: rtl/memex_stage.sv
// MEMEX stage: data-bus / ITCM access, load formatting, and the MEMEX/WB register.
// Optional bus-wait abort is enabled by defining LSU_TIMEOUT_EN.
module memex_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        invalid_MEMEX,
    input  logic [31:0] pc4_MEMEX,
    input  logic [3:0]  rd_MEMEX,
    input  logic [31:0] alu_result_MEMEX,
    input  logic        regfile_we_MEMEX,
    input  logic [1:0]  rd_data_sel_MEMEX,
    input  logic        lsu_sign_extend_MEMEX,
    input  logic [1:0]  data_width_MEMEX,
    input  logic [31:0] immediate_MEMEX,
    input  logic        itcm_we_MEMEX,
    input  logic [31:0] rs2_data_MEMEX,
    input  logic        dmem_we_MEMEX,
    output logic        stall_MEMEX,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        itcm_we,
    output logic [31:0] itcm_addr,
    output logic [31:0] itcm_wdata,
    output logic [3:0]  itcm_be,
    output logic [3:0]  rd_WB,
    output logic [31:0] rd_data_WB,
    output logic        regfile_we_WB,
    output logic        lsu_fault_WB
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      state_q;
    logic [1:0]  ofs;
    logic        valid;
    logic        is_load;
    logic        dmem_store;
    logic        is_access;
    logic        misaligned;
    logic        align_fault;
    logic        bus_op;
    logic        timeout_abort;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        wb_fault;

    assign ofs        = alu_result_MEMEX[1:0];
    assign valid      = !invalid_MEMEX;
    assign is_load    = (rd_data_sel_MEMEX == 2'b01);
    // ITCM write takes priority over a simultaneous dmem store.
    assign dmem_store = dmem_we_MEMEX && !itcm_we_MEMEX;
    assign is_access  = is_load || dmem_we_MEMEX || itcm_we_MEMEX;

    always_comb begin
        misaligned = 1'b1;
        be         = 4'b1111;
        wdata      = rs2_data_MEMEX;
        unique case (data_width_MEMEX)
            2'b00: begin
                misaligned = 1'b0;
                be         = 4'b0001 << ofs;
                wdata      = {4{rs2_data_MEMEX[7:0]}};
            end
            2'b01: begin
                misaligned = ofs[0];
                be         = 4'b0011 << ofs;
                wdata      = {2{rs2_data_MEMEX[15:0]}};
            end
            2'b10: misaligned = |ofs;
            default: misaligned = 1'b1;
        endcase
    end

    assign align_fault = valid && is_access && misaligned;
    assign bus_op      = valid && !misaligned && (is_load || dmem_store);

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CntW-1:0] cnt_q;

    assign timeout_abort = (state_q == StWait) && !dbus_ack &&
                           (cnt_q >= CntW'(TIMEOUT_CYCLES));
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout_abort  = 1'b0;
`endif

    // Upstream holds the MEMEX inputs while stalled, so the request stays stable.
    assign dbus_req    = bus_op && !timeout_abort && !rst;
    assign dbus_we     = dbus_req && dmem_store;
    assign dbus_addr   = alu_result_MEMEX;
    assign dbus_wdata  = wdata;
    assign dbus_be     = be;
    assign stall_MEMEX = dbus_req && !dbus_ack;

    assign itcm_we    = valid && itcm_we_MEMEX && !misaligned && !rst;
    assign itcm_addr  = alu_result_MEMEX;
    assign itcm_wdata = wdata;
    assign itcm_be    = be;

    assign shifted = dbus_rdata >> {ofs, 3'b000};

    always_comb begin
        load_data = shifted;
        unique case (data_width_MEMEX)
            2'b00:   load_data = {{24{lsu_sign_extend_MEMEX && shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{lsu_sign_extend_MEMEX && shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        wb_data = alu_result_MEMEX;
        unique case (rd_data_sel_MEMEX)
            2'b00: wb_data = alu_result_MEMEX;
            2'b01: wb_data = load_data;
            2'b10: wb_data = pc4_MEMEX;
            2'b11: wb_data = immediate_MEMEX;
        endcase
    end

    assign wb_we    = valid && regfile_we_MEMEX && !align_fault && !timeout_abort;
    assign wb_fault = align_fault || timeout_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            rd_WB         <= 4'd0;
            rd_data_WB    <= 32'd0;
            regfile_we_WB <= 1'b0;
            lsu_fault_WB  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q <= stall_MEMEX ? StWait : StIdle;
`ifdef LSU_TIMEOUT_EN
            if (state_q == StIdle) begin
                cnt_q <= '0;
            end else if (stall_MEMEX) begin
                cnt_q <= cnt_q + 1'b1;
            end
`endif
            if (!stall_MEMEX) begin
                rd_WB         <= rd_MEMEX;
                rd_data_WB    <= wb_data;
                regfile_we_WB <= wb_we;
                lsu_fault_WB  <= wb_fault;
            end
        end
    end

endmodule

// File: tb/tb_memex_stage.sv
// Table-driven bench for memex_stage with a write-back scoreboard.
module tb_memex_stage;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst;
    logic        invalid_MEMEX;
    logic [31:0] pc4_MEMEX;
    logic [3:0]  rd_MEMEX;
    logic [31:0] alu_result_MEMEX;
    logic        regfile_we_MEMEX;
    logic [1:0]  rd_data_sel_MEMEX;
    logic        lsu_sign_extend_MEMEX;
    logic [1:0]  data_width_MEMEX;
    logic [31:0] immediate_MEMEX;
    logic        itcm_we_MEMEX;
    logic [31:0] rs2_data_MEMEX;
    logic        dmem_we_MEMEX;
    logic        stall_MEMEX;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        itcm_we;
    logic [31:0] itcm_addr;
    logic [31:0] itcm_wdata;
    logic [3:0]  itcm_be;
    logic [3:0]  rd_WB;
    logic [31:0] rd_data_WB;
    logic        regfile_we_WB;
    logic        lsu_fault_WB;

    memex_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .invalid_MEMEX         (invalid_MEMEX),
        .pc4_MEMEX             (pc4_MEMEX),
        .rd_MEMEX              (rd_MEMEX),
        .alu_result_MEMEX      (alu_result_MEMEX),
        .regfile_we_MEMEX      (regfile_we_MEMEX),
        .rd_data_sel_MEMEX     (rd_data_sel_MEMEX),
        .lsu_sign_extend_MEMEX (lsu_sign_extend_MEMEX),
        .data_width_MEMEX      (data_width_MEMEX),
        .immediate_MEMEX       (immediate_MEMEX),
        .itcm_we_MEMEX         (itcm_we_MEMEX),
        .rs2_data_MEMEX        (rs2_data_MEMEX),
        .dmem_we_MEMEX         (dmem_we_MEMEX),
        .stall_MEMEX           (stall_MEMEX),
        .dbus_req              (dbus_req),
        .dbus_we               (dbus_we),
        .dbus_addr             (dbus_addr),
        .dbus_wdata            (dbus_wdata),
        .dbus_be               (dbus_be),
        .dbus_ack              (dbus_ack),
        .dbus_rdata            (dbus_rdata),
        .itcm_we               (itcm_we),
        .itcm_addr             (itcm_addr),
        .itcm_wdata            (itcm_wdata),
        .itcm_be               (itcm_be),
        .rd_WB                 (rd_WB),
        .rd_data_WB            (rd_data_WB),
        .regfile_we_WB         (regfile_we_WB),
        .lsu_fault_WB          (lsu_fault_WB)
    );

    typedef struct {
        string       name;
        logic        inv;
        logic [1:0]  sel;
        logic [1:0]  width;
        logic        sext;
        logic        dwe;
        logic        iwe;
        logic        rfwe;
        logic [3:0]  rd;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          delay;
        logic        x_req;
        logic        x_bwe;
        logic [3:0]  x_be;
        logic [31:0] x_wdata;
        logic        x_itcm;
        logic [31:0] x_data;
        logic        x_we;
        logic        x_fault;
        logic        x_chk;
    } vec_t;

    typedef struct {
        string       name;
        logic [3:0]  rd;
        logic [31:0] data;
        logic        we;
        logic        fault;
        logic        chk;
    } wb_t;

    vec_t vecs[$];
    wb_t  sb[$];
    int   total  = 0;
    int   passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Pops one expectation on every edge where the stage accepts its result.
    initial begin
        wb_t e;
        forever begin
            @(posedge clk);
            if (!rst && !stall_MEMEX && sb.size() > 0) begin
                e = sb.pop_front();
                #1;
                chk({e.name, ".wb_we"}, 32'(regfile_we_WB), 32'(e.we));
                chk({e.name, ".wb_fault"}, 32'(lsu_fault_WB), 32'(e.fault));
                if (e.chk) begin
                    chk({e.name, ".wb_rd"}, 32'(rd_WB), 32'(e.rd));
                    chk({e.name, ".wb_data"}, rd_data_WB, e.data);
                end
            end
        end
    end

    task automatic drive(input vec_t v);
        invalid_MEMEX         = v.inv;
        rd_data_sel_MEMEX     = v.sel;
        data_width_MEMEX      = v.width;
        lsu_sign_extend_MEMEX = v.sext;
        dmem_we_MEMEX         = v.dwe;
        itcm_we_MEMEX         = v.iwe;
        regfile_we_MEMEX      = v.rfwe;
        rd_MEMEX              = v.rd;
        alu_result_MEMEX      = v.addr;
        rs2_data_MEMEX        = v.rs2;
        dbus_rdata            = v.rdata;
    endtask

    task automatic run_nop();
        wb_t e;
        @(negedge clk);
        invalid_MEMEX     = 1'b1;
        rd_data_sel_MEMEX = 2'b00;
        dmem_we_MEMEX     = 1'b0;
        itcm_we_MEMEX     = 1'b0;
        regfile_we_MEMEX  = 1'b1;
        rd_MEMEX          = 4'hF;
        alu_result_MEMEX  = 32'hFFFF_0000;
        dbus_ack          = 1'b0;
        e = '{"nop", 4'hF, 32'h0, 1'b0, 1'b0, 1'b0};
        sb.push_back(e);
        #1;
        chk("nop.req", 32'(dbus_req), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        wb_t e;
        @(negedge clk);
        drive(v);
        dbus_ack = (v.delay == 0);
        e = '{v.name, v.rd, v.x_data, v.x_we, v.x_fault, v.x_chk};
        sb.push_back(e);
        #1;
        chk({v.name, ".req"}, 32'(dbus_req), 32'(v.x_req));
        chk({v.name, ".itcm_we"}, 32'(itcm_we), 32'(v.x_itcm));
        chk({v.name, ".stall"}, 32'(stall_MEMEX), 32'(v.x_req && v.delay > 0));
        if (v.x_req) begin
            chk({v.name, ".bus_we"}, 32'(dbus_we), 32'(v.x_bwe));
            chk({v.name, ".bus_be"}, 32'(dbus_be), 32'(v.x_be));
            chk({v.name, ".bus_addr"}, dbus_addr, v.addr);
            if (v.x_bwe) chk({v.name, ".bus_wdata"}, dbus_wdata, v.x_wdata);
        end
        if (v.x_itcm) begin
            chk({v.name, ".itcm_be"}, 32'(itcm_be), 32'(v.x_be));
            chk({v.name, ".itcm_addr"}, itcm_addr, v.addr);
            chk({v.name, ".itcm_wdata"}, itcm_wdata, v.x_wdata);
        end
        for (int k = 1; k <= v.delay; k++) begin
            @(negedge clk);
            dbus_ack = (k == v.delay);
            #1;
            chk({v.name, ".wait_req"}, 32'(dbus_req), 32'd1);
            chk({v.name, ".wait_addr"}, dbus_addr, v.addr);
            chk({v.name, ".wait_be"}, 32'(dbus_be), 32'(v.x_be));
            chk({v.name, ".wait_stall"}, 32'(stall_MEMEX), 32'(k < v.delay));
        end
    endtask

    initial begin
        int n;
        wb_t e;
        // name inv sel width sext dwe iwe rfwe rd addr rs2 rdata delay |
        // req bwe be wdata itcm data we fault chk
        vecs.push_back('{"ld_w_0w", 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5,
            32'h100, 32'h1122_3344, 32'hDEAD_BEEF, 0,
            1'b1, 1'b0, 4'b1111, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"ld_b_s_3w", 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6,
            32'h103, 32'h1122_3344, 32'h8012_3456, 3,
            1'b1, 1'b0, 4'b1000, 32'h0, 1'b0, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"ld_b_u_2w", 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7,
            32'h103, 32'h1122_3344, 32'h8012_3456, 2,
            1'b1, 1'b0, 4'b1000, 32'h0, 1'b0, 32'h0000_0080, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"st_h_1w", 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,
            32'h202, 32'h1234_ABCD, 32'h0, 1,
            1'b1, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h202, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"ld_w_mis", 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8,
            32'h101, 32'h0, 32'h0, 0,
            1'b0, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"ld_inv", 1'b1, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8,
            32'h100, 32'h0, 32'h0, 0,
            1'b0, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"itcm_b", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,
            32'h41, 32'h77, 32'h0, 0,
            1'b0, 1'b0, 4'b0010, 32'h7777_7777, 1'b1, 32'h41, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"alu_ack", 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9,
            32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 0,
            1'b0, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"sel_pc4", 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10,
            32'h55, 32'h0, 32'h0, 0,
            1'b0, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h0000_1004, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"sel_imm", 1'b0, 2'b11, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 4'd11,
            32'h55, 32'h0, 32'h0, 0,
            1'b0, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h0000_0ABC, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"ld_h_s", 1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 4'd12,
            32'h102, 32'h0, 32'h8001_1234, 0,
            1'b1, 1'b0, 4'b1100, 32'h0, 1'b0, 32'hFFFF_8001, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"st_itcm_win", 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,
            32'h40, 32'hCAFE_F00D, 32'h0, 0,
            1'b0, 1'b0, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h40, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"st_h_mis", 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,
            32'h203, 32'h0, 32'h0, 0,
            1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"ld_illegal", 1'b0, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 4'd13,
            32'h100, 32'h0, 32'h0, 0,
            1'b0, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"ld_w_1w", 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 4'd14,
            32'h10C, 32'h0, 32'h0BAD_F00D, 1,
            1'b1, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b1});

        // Reset with a valid aligned load presented: outputs must still be quiet.
        rst                   = 1'b1;
        pc4_MEMEX             = 32'h0000_1004;
        immediate_MEMEX       = 32'h0000_0ABC;
        invalid_MEMEX         = 1'b0;
        rd_data_sel_MEMEX     = 2'b01;
        data_width_MEMEX      = 2'b10;
        lsu_sign_extend_MEMEX = 1'b0;
        dmem_we_MEMEX         = 1'b0;
        itcm_we_MEMEX         = 1'b1;
        regfile_we_MEMEX      = 1'b1;
        rd_MEMEX              = 4'd1;
        alu_result_MEMEX      = 32'h100;
        rs2_data_MEMEX        = 32'h0;
        dbus_ack              = 1'b0;
        dbus_rdata            = 32'h0;
        #2;
        chk("rst.req", 32'(dbus_req), 32'd0);
        chk("rst.stall", 32'(stall_MEMEX), 32'd0);
        chk("rst.itcm_we", 32'(itcm_we), 32'd0);
        chk("rst.rd_WB", 32'(rd_WB), 32'd0);
        chk("rst.rd_data_WB", rd_data_WB, 32'd0);
        chk("rst.we_WB", 32'(regfile_we_WB), 32'd0);
        chk("rst.fault_WB", 32'(lsu_fault_WB), 32'd0);
        @(negedge clk);
        invalid_MEMEX = 1'b1;
        itcm_we_MEMEX = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
            run_nop();
        end

        // Reset while waiting for an ack; a late ack afterwards is ignored.
        @(negedge clk);
        e.name = "rst_wait";
        drive('{"rst_wait", 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3,
            32'h300, 32'h0, 32'h1111_1111, 0,
            1'b0, 1'b0, 4'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
        dbus_ack = 1'b0;
        #1;
        chk("rst_wait.stall0", 32'(stall_MEMEX), 32'd1);
        @(negedge clk);
        #1;
        chk("rst_wait.stall1", 32'(stall_MEMEX), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_wait.req", 32'(dbus_req), 32'd0);
        chk("rst_wait.stall", 32'(stall_MEMEX), 32'd0);
        chk("rst_wait.rd_WB", 32'(rd_WB), 32'd0);
        chk("rst_wait.rd_data_WB", rd_data_WB, 32'd0);
        chk("rst_wait.we_WB", 32'(regfile_we_WB), 32'd0);
        invalid_MEMEX = 1'b1;
        dbus_ack      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("late_ack.we_WB", 32'(regfile_we_WB), 32'd0);
        chk("late_ack.stall", 32'(stall_MEMEX), 32'd0);
        dbus_ack = 1'b0;

`ifdef LSU_TIMEOUT_EN
        // Never-acked load: one IDLE stall cycle plus TO stalled WAIT cycles, then abort.
        @(negedge clk);
        drive('{"timeout", 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2,
            32'h400, 32'h0, 32'h0, 0,
            1'b0, 1'b0, 4'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
        e = '{"timeout", 4'd2, 32'h0, 1'b0, 1'b1, 1'b0};
        sb.push_back(e);
        n = 0;
        #1;
        while (stall_MEMEX && n < 600) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("timeout.stall_cycles", 32'(n), 32'(TO + 1));
        chk("timeout.req", 32'(dbus_req), 32'd0);
        run_nop();
`endif

        run_nop();
        repeat (2) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/memex_stage.md
# memex_stage

MEMEX pipeline stage of the RV32E core: consumes the MEMPREP/MEMEX pipeline register outputs and performs the data-memory or ITCM access. It formats load data and selects the register-file write-back value. It drives a req/ack data bus, stalls upstream while an access is outstanding, and registers the result into the MEMEX/WB boundary.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: bus wait limit before abort. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  stage clock
- rst  in  1  reset; asynchronous, active-high
- invalid_MEMEX, pc4_MEMEX, rd_MEMEX[3:0], alu_result_MEMEX, regfile_we_MEMEX, rd_data_sel_MEMEX[1:0], lsu_sign_extend_MEMEX, data_width_MEMEX[1:0], immediate_MEMEX, itcm_we_MEMEX, rs2_data_MEMEX  in  per name  from the MEMPREP/MEMEX register
- dmem_we_MEMEX  in  1  data store
- stall_MEMEX  out  1  freeze upstream; MEMEX inputs must stay stable while high
- dbus_req  out  1  bus request
- dbus_we  out  1  write request
- dbus_addr  out  32  bus address
- dbus_wdata  out  32  bus write data
- dbus_be  out  4  bus byte enables
- dbus_ack  in  1  bus completion; may arrive in the same cycle as req
- dbus_rdata  in  32  read data, valid with ack
- itcm_we  out  1  ITCM write strobe
- itcm_addr  out  32  ITCM address
- itcm_wdata  out  32  ITCM write data
- itcm_be  out  4  ITCM byte enables
- rd_WB  out  4  destination register
- rd_data_WB  out  32  write-back data
- regfile_we_WB  out  1  write-back enable
- lsu_fault_WB  out  1  one-cycle fault pulse

## Operation
- rd_data_sel encoding:
  - 00 alu_result
  - 01 load data
  - 10 pc4
  - 11 immediate
- Load means rd_data_sel=01. Store means dmem_we.
- If itcm_we is set together with dmem_we, ITCM wins and the dmem store is suppressed.
- Addressing:
  - All addresses equal alu_result_MEMEX.
  - Width 00 = byte, 01 = half, 10 = word, 11 = illegal.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0, or width 11. A misaligned access:
  - issues no bus or ITCM access;
  - forces regfile_we_WB=0;
  - pulses lsu_fault_WB.
- Byte enables:
  - byte: 0001<<addr[1:0]
  - half: 0011<<addr[1:0]
  - word: 1111
- Store data:
  - byte: replicated {4{rs2[7:0]}}
  - half: replicated {2{rs2[15:0]}}
  - word: rs2
- Load data: dbus_rdata>>(8·addr[1:0]), masked to the width, then sign-extended if lsu_sign_extend, else zero-extended.
- invalid_MEMEX=1:
  - no bus or ITCM activity;
  - no stall;
  - regfile_we_WB=0;
  - no fault.
- FSM states:
  - IDLE:
    - A valid aligned load or dmem store drives dbus_req (combinationally from the inputs).
    - With ack in the same cycle: completes, no stall.
    - Without ack: goes to WAIT, stall_MEMEX=1.
  - WAIT:
    - dbus_req and address/data held, stall_MEMEX=1.
    - On ack: captures the result, stall_MEMEX=0 in that cycle, returns to IDLE.
- ITCM write: single cycle, no handshake, never stalls. itcm_we = itcm_we_MEMEX & valid & aligned.
- Write-back registers load on every clk edge where stall_MEMEX=0.
  - Stores and ITCM writes pass regfile_we through, which is normally 0 from decode.

## Timing
- Reset (asynchronous), effective immediately:
  - FSM → IDLE;
  - dbus_req, stall_MEMEX, itcm_we → 0;
  - rd_WB, rd_data_WB, regfile_we_WB, lsu_fault_WB → 0.
- Reset in WAIT drops req without waiting for ack; a late ack after reset is ignored.
- Non-memory op, ITCM write, or zero-wait access: result visible on the WB outputs 1 cycle after being presented.
- Access with N wait cycles (ack N cycles after first req): stall_MEMEX high for N cycles; WB outputs update at the edge ending the ack cycle.
- dbus_req, dbus_we, dbus_addr, dbus_wdata and dbus_be are stable from first assertion until ack.
- ack while not requesting: ignored.
- lsu_fault_WB: high for exactly one cycle per faulting instruction.

## Configuration
- LSU_TIMEOUT_EN defined:
  - An 8+-bit counter (sized for TIMEOUT_CYCLES) clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without ack:
    - drops req, returns to IDLE, releases the stall;
    - regfile_we_WB=0;
    - lsu_fault_WB pulses.
- LSU_TIMEOUT_EN undefined:
  - WAIT lasts until ack indefinitely;
  - bus faults never occur (lsu_fault_WB still reports misalignment).

## Test plan
- Word load, addr 0x100, ack same cycle, rdata 0xDEADBEEF, rd=5 -> no stall; next cycle rd_WB=5, rd_data_WB=0xDEADBEEF, regfile_we_WB=1.
- Signed byte load, addr 0x103, ack after 3 cycles, rdata 0x80xxxxxx -> stall 3 cycles, req/addr stable, rd_data_WB=0xFFFFFF80; unsigned variant gives 0x00000080.
- Half store, addr 0x202, rs2=0x1234ABCD, ack after 1 cycle -> dbus_we=1, dbus_be=1100, dbus_wdata=0xABCDABCD, stall 1 cycle.
- Word load at 0x101 -> no dbus_req, regfile_we_WB=0, lsu_fault_WB pulses 1 cycle; a valid load with invalid_MEMEX=1 -> no req, no write, no fault.
- Byte ITCM write, addr 0x41, rs2=0x77 -> itcm_we=1 for one cycle, itcm_be=0010, itcm_wdata=0x77777777, no stall.
- Reset asserted in WAIT -> req and stall drop immediately, WB outputs 0. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, a never-acked load -> stall released after 4 WAIT cycles, lsu_fault_WB pulses.
